// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter IC pulse sequencer: state encoding,
// default pulse timing and a helper to size the phase timer.
package counter_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLK_LOW,
      CLK_HIGH,
      RST_ACT,
      RST_GAP
   } seq_state_t;

   // 100 cycles at 100 MHz gives a 1 us phase, slow enough for the loaded pins
   localparam int DEFAULT_PULSE_CYCLES = 100;
   localparam int DEFAULT_GAP_CYCLES   = 100;
   localparam int DEFAULT_NUM_CLK_OUT  = 4;
   localparam int DEFAULT_CNT_W        = 8;

   // Width of a down-counter that must hold the longer of the two phase lengths
   function automatic int timer_width(input int pulse_cycles, input int gap_cycles);
      int longest;
      longest = (pulse_cycles > gap_cycles) ? pulse_cycles : gap_cycles;
      return $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/counter_pulse_timer.sv
// Loadable phase down-counter shared by every sequencer phase. A start
// strobe loads (length - 1); expired is high in the last cycle of the phase.
module counter_pulse_timer
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             start,
   input  logic [WIDTH-1:0] load_value,
   output logic             expired
);

   logic [WIDTH-1:0] count;
   logic             running;

   // Count down once started; a new start always wins so phases chain back to back
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         count   <= '0;
         running <= 1'b0;
      end else if (start) begin
         count   <= load_value;
         running <= 1'b1;
      end else if (running) begin
         if (count == '0) begin
            running <= 1'b0;
         end else begin
            count <= count - 1'b1;
         end
      end
   end

   assign expired = running && (count == '0);

endmodule

// File: rtl/counter_pulse_sequencer.sv
// Generates bursts of counter clock pulses or a single counter reset pulse
// with programmable active and recovery widths. All outputs are registered.
module counter_pulse_sequencer
   import counter_ctrl_pkg::*;
#(
   parameter int NUM_CLK_OUT  = DEFAULT_NUM_CLK_OUT,
   parameter int PULSE_CYCLES = DEFAULT_PULSE_CYCLES,
   parameter int GAP_CYCLES   = DEFAULT_GAP_CYCLES,
   parameter int CNT_W        = DEFAULT_CNT_W
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   ADVANCE_REQ,
   input  logic [CNT_W-1:0]       ADVANCE_COUNT,
   input  logic                   RESET_REQ,
   input  logic                   ABORT,
   output logic [NUM_CLK_OUT-1:0] COUNTER_CLK,
   output logic                   COUNTER_RST,
   output logic                   BUSY,
   output logic                   DONE,
   output logic [CNT_W-1:0]       PULSES_LEFT
);

   localparam int TW = timer_width(PULSE_CYCLES, GAP_CYCLES);
   localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

   if (PULSE_CYCLES < 1 || GAP_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
      $error("counter_pulse_sequencer: PULSE_CYCLES, GAP_CYCLES and CNT_W must all be >= 1");
   end

   seq_state_t state;
   seq_state_t state_nxt;
   logic [CNT_W-1:0] pulses_nxt;
   logic [CNT_W-1:0] pulses_dec;
   logic abort_flag;
   logic abort_nxt;
   logic timer_start;
   logic [TW-1:0] timer_load;
   logic timer_expired;
   logic [NUM_CLK_OUT-1:0] clk_nxt;
   logic rst_nxt;
   logic busy_nxt;
   logic done_nxt;

   assign pulses_dec = PULSES_LEFT - 1'b1;

   counter_pulse_timer #(
      .WIDTH(TW)
   ) u_timer (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .start     (timer_start),
      .load_value(timer_load),
      .expired   (timer_expired)
   );

   // State, burst bookkeeping and the registered pin outputs
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state       <= IDLE;
         abort_flag  <= 1'b0;
         PULSES_LEFT <= '0;
         COUNTER_CLK <= '1;
         COUNTER_RST <= 1'b0;
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
      end else begin
         state       <= state_nxt;
         abort_flag  <= abort_nxt;
         PULSES_LEFT <= pulses_nxt;
         COUNTER_CLK <= clk_nxt;
         COUNTER_RST <= rst_nxt;
         BUSY        <= busy_nxt;
         DONE        <= done_nxt;
      end
   end

   // Phase sequencing; an abort seen anywhere in a pulse ends the burst after that pulse
   always_comb begin
      state_nxt   = state;
      pulses_nxt  = PULSES_LEFT;
      abort_nxt   = abort_flag;
      timer_start = 1'b0;
      timer_load  = '0;
      case (state)
         IDLE: begin
            abort_nxt = 1'b0;
            if (RESET_REQ) begin
               state_nxt   = RST_ACT;
               timer_start = 1'b1;
               timer_load  = PULSE_LOAD;
            end else if (ADVANCE_REQ && (ADVANCE_COUNT != '0)) begin
               state_nxt   = CLK_LOW;
               pulses_nxt  = ADVANCE_COUNT;
               timer_start = 1'b1;
               timer_load  = PULSE_LOAD;
            end
         end
         CLK_LOW: begin
            if (ABORT) begin
               abort_nxt = 1'b1;
            end
            if (timer_expired) begin
               state_nxt   = CLK_HIGH;
               timer_start = 1'b1;
               timer_load  = GAP_LOAD;
            end
         end
         CLK_HIGH: begin
            if (ABORT) begin
               abort_nxt = 1'b1;
            end
            if (timer_expired) begin
               if ((pulses_dec != '0) && !abort_nxt) begin
                  state_nxt   = CLK_LOW;
                  pulses_nxt  = pulses_dec;
                  timer_start = 1'b1;
                  timer_load  = PULSE_LOAD;
               end else begin
                  state_nxt  = IDLE;
                  pulses_nxt = '0;
                  abort_nxt  = 1'b0;
               end
            end
         end
         RST_ACT: begin
            if (timer_expired) begin
               state_nxt   = RST_GAP;
               timer_start = 1'b1;
               timer_load  = GAP_LOAD;
            end
         end
         RST_GAP: begin
            if (timer_expired) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt  = IDLE;
            pulses_nxt = '0;
            abort_nxt  = 1'b0;
         end
      endcase
   end

   // Pin values for the upcoming state, so the registered outputs track the state with no lag
   always_comb begin
      clk_nxt  = (state_nxt == CLK_LOW) ? '0 : '1;
      rst_nxt  = (state_nxt == RST_ACT);
      busy_nxt = (state_nxt != IDLE);
      done_nxt = (state != IDLE) && (state_nxt == IDLE);
   end

endmodule

// File: doc/counter_pulse_sequencer.md
# counter_pulse_sequencer

Parametrised controller for the negative-edge-triggered counter ICs on the ASIC tester board. It generates a burst of N clock pulses or one reset pulse on request, with independently programmable low and high widths to meet the slow-slew requirement of the heavily loaded FPGA pins. It sits between the test-sequencing FSM and the counter IC pins. It drives NUM_CLK_OUT identical clock outputs and reports progress and completion.

## Interface
- NUM_CLK_OUT, 4: number of identical counter clock outputs.
- PULSE_CYCLES, 100: CLK periods an active pulse is held (clock low / reset high); ≥1.
- GAP_CYCLES, 100: CLK periods of recovery after each pulse (clock high / reset low); ≥1.
- CNT_W, 8: width of the burst-length request.
- CLK  in  1  system clock (100 MHz); one clock domain.
- RST_N  in  1  reset, synchronous, active-low.
- ADVANCE_REQ  in  1  start a clock burst; sampled in IDLE only.
- ADVANCE_COUNT  in  CNT_W  number of falling edges in the burst; sampled with ADVANCE_REQ.
- RESET_REQ  in  1  start a counter reset pulse; sampled in IDLE only.
- ABORT  in  1  end the burst after the pulse in progress.
- COUNTER_CLK  out  NUM_CLK_OUT  counter IC clocks; all bits always identical.
- COUNTER_RST  out  1  counter IC reset, active-high.
- BUSY  out  1  high while a sequence is in progress.
- DONE  out  1  one-cycle strobe at sequence completion.
- PULSES_LEFT  out  CNT_W  pulses remaining, including the current one; 0 in IDLE.

## Operation
- All outputs are registered.
- Reset values: COUNTER_CLK all 1, COUNTER_RST 0, BUSY 0, DONE 0, PULSES_LEFT 0, state IDLE.
- States: IDLE, CLK_LOW, CLK_HIGH, RST_ACT, RST_GAP.
- IDLE:
  - If RESET_REQ=1, go to RST_ACT. RESET_REQ has priority when it is high together with ADVANCE_REQ.
  - Else if ADVANCE_REQ=1 and ADVANCE_COUNT≠0, go to CLK_LOW and load PULSES_LEFT=ADVANCE_COUNT.
  - ADVANCE_REQ with ADVANCE_COUNT=0 is ignored: no BUSY, no DONE.
- CLK_LOW: COUNTER_CLK=0 for PULSE_CYCLES cycles, then go to CLK_HIGH.
- CLK_HIGH: COUNTER_CLK=1 for GAP_CYCLES cycles. At the end:
  - decrement PULSES_LEFT;
  - if the result is ≠0 and no abort is latched, go to CLK_LOW;
  - otherwise go to IDLE.
- RST_ACT: COUNTER_RST=1 for PULSE_CYCLES cycles, then go to RST_GAP.
- RST_GAP: COUNTER_RST=0 for GAP_CYCLES cycles, then go to IDLE.
- ABORT:
  - ABORT=1 in CLK_LOW or CLK_HIGH latches an abort flag. The current low+high pulse always completes, so no runt pulse occurs.
  - The flag clears on entry to IDLE.
  - ABORT is ignored in IDLE, RST_ACT and RST_GAP.
- Requests are ignored while BUSY=1. No queuing: the requester re-asserts after DONE.
- Counter IC action on reset: the falling edges of COUNTER_CLK equal the number of CLK_LOW entries.

## Timing
- Request accepted at edge k: BUSY=1 and the pulse output becomes active at edge k; zero extra latency.
- Active phase length: exactly PULSE_CYCLES cycles. Gap phase length: exactly GAP_CYCLES cycles.
- Burst of N with no abort: BUSY high for N·(PULSE_CYCLES+GAP_CYCLES) cycles.
- Reset sequence: BUSY high for PULSE_CYCLES+GAP_CYCLES cycles.
- Completion: at the edge entering IDLE, BUSY←0, DONE←1, PULSES_LEFT=0. DONE falls on the following edge.
- A request present in the first IDLE cycle, while DONE=1, is accepted. This gives back-to-back sequences with a single idle cycle.
- RST_N=0 mid-sequence: at the next edge all outputs take their reset values and the pulse is truncated. The counter IC state is then undefined; software must issue RESET_REQ.
- Phase timer: loadable down-counter of width $clog2(max(PULSE_CYCLES,GAP_CYCLES)+1).
- PULSES_LEFT wrap: impossible, because it only decrements from a nonzero value.

## Structure
- Shared package counter_ctrl_pkg:
  - state enum seq_state_t;
  - default constants for PULSE_CYCLES and GAP_CYCLES (100 at 100 MHz = 1 µs);
  - NUM_CLK_OUT default.
- Sub-module counter_pulse_timer:
  - parametrised width;
  - load value, start, and expired strobe;
  - one instance is shared by all phases.
- Elaboration-time check: PULSE_CYCLES≥1, GAP_CYCLES≥1, CNT_W≥1.

## Test plan
Parameters for all scenarios: NUM_CLK_OUT=4, PULSE_CYCLES=4, GAP_CYCLES=3, CNT_W=8.
- After reset release, ADVANCE_REQ with ADVANCE_COUNT=1 for one cycle:
  - COUNTER_CLK=4'b0000 for 4 cycles, then 4'b1111 for 3 cycles;
  - BUSY high 7 cycles;
  - DONE one cycle at cycle 7.
- ADVANCE_COUNT=5:
  - exactly 5 falling edges on every COUNTER_CLK bit;
  - PULSES_LEFT steps 5→0;
  - BUSY high 35 cycles.
- RESET_REQ and ADVANCE_REQ asserted together:
  - COUNTER_RST high 4 cycles, then low 3 cycles;
  - COUNTER_CLK stays 1111;
  - DONE after 7 cycles.
- ADVANCE_COUNT=10 with ABORT pulsed during the 3rd CLK_LOW:
  - exactly 3 full pulses occur;
  - DONE at cycle 21.
- ADVANCE_REQ re-asserted in the DONE cycle: the new burst starts on that edge. ADVANCE_REQ with ADVANCE_COUNT=0: no BUSY, no DONE.
- RST_N=0 during CLK_LOW of a 5-pulse burst: the next edge gives COUNTER_CLK=1111, BUSY=0, PULSES_LEFT=0, DONE=0.
